// File: rtl/fir_inv_pkg.sv
// Shared constants, state encoding and clamp helpers for the inverse FIR recovery filter.
// Also used by the interface, the history register and the top level.
package fir_inv_pkg;

   localparam int DW_IN  = 10;
   localparam int DW_OUT = 8;
   localparam int ACC_W  = 17;

   localparam int TAP_FIRST = 1;
   localparam int TAP_LAST  = 4;

   localparam int CLAMP_LO = 0;
   localparam int CLAMP_HI = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   function automatic logic is_sat(input logic signed [ACC_W-1:0] a);
      return (a < ACC_W'(CLAMP_LO)) || (a > ACC_W'(CLAMP_HI));
   endfunction

   function automatic logic [DW_OUT-1:0] clamp_acc(input logic signed [ACC_W-1:0] a);
      if (a < ACC_W'(CLAMP_LO)) begin
         return DW_OUT'(CLAMP_LO);
      end else if (a > ACC_W'(CLAMP_HI)) begin
         return DW_OUT'(CLAMP_HI);
      end
      return a[DW_OUT-1:0];
   endfunction

endpackage

// File: rtl/fir_inverse_seq_if.sv
// Filtered-sample input and recovered-sample output handshakes of the inverse FIR.
// sat_flag is present only when FIR_INV_SAT_FLAG_EN is defined.
interface fir_inverse_seq_if;

   logic [fir_inv_pkg::DW_IN-1:0]  y_in;
   logic                           y_valid;
   logic                           y_ready;
   logic [fir_inv_pkg::DW_OUT-1:0] x_out;
   logic                           x_valid;
   logic                           x_ready;
`ifdef FIR_INV_SAT_FLAG_EN
   logic                           sat_flag;

   modport master (output y_in, y_valid, x_ready, input y_ready, x_out, x_valid, sat_flag);
   modport slave  (input y_in, y_valid, x_ready, output y_ready, x_out, x_valid, sat_flag);
`else
   modport master (output y_in, y_valid, x_ready, input y_ready, x_out, x_valid);
   modport slave  (input y_in, y_valid, x_ready, output y_ready, x_out, x_valid);
`endif

endinterface

// File: rtl/fir_inv_hist.sv
// Four-deep history of recovered samples; h1 is the newest, shifts on shift_en.
// Synchronous active-high reset clears all entries.
module fir_inv_hist #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         shift_en,
   input  logic [W-1:0] din,
   output logic [W-1:0] h1,
   output logic [W-1:0] h2,
   output logic [W-1:0] h3,
   output logic [W-1:0] h4
);

   logic [3:0][W-1:0] h_q;
   logic [3:0][W-1:0] h_d;

   always_comb begin
      h_d = h_q;
      if (shift_en) begin
         h_d = {h_q[2:0], din};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q <= '0;
      end else begin
         h_q <= h_d;
      end
   end

   assign h1 = h_q[0];
   assign h2 = h_q[1];
   assign h3 = h_q[2];
   assign h4 = h_q[3];

endmodule

// File: rtl/fir_inverse_seq.sv
// Sequential inverse of the 5-tap shift FIR: x = clamp(32y - 2h1 - 4h2 - 8h3 - 16h4), one tap per cycle.
// Accept-to-x_valid latency 5 cycles, initiation interval 7; output holds while x_ready is low.
// Optional sat_flag output under FIR_INV_SAT_FLAG_EN.
module fir_inverse_seq #(
   parameter int DW_IN  = fir_inv_pkg::DW_IN,
   parameter int DW_OUT = fir_inv_pkg::DW_OUT,
   parameter int ACC_W  = fir_inv_pkg::ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   fir_inverse_seq_if.slave  bus
);

   import fir_inv_pkg::*;

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [2:0]               tap_q, tap_d;
   logic [DW_OUT-1:0]        x_out_q, x_out_d;
   logic                     x_valid_q, x_valid_d;
   logic                     y_ready_q, y_ready_d;
`ifdef FIR_INV_SAT_FLAG_EN
   logic                     sat_q, sat_d;
`endif

   logic [DW_OUT-1:0]        h1, h2, h3, h4;
   logic [DW_OUT-1:0]        h_sel;
   logic [ACC_W-1:0]         sub_term;
   logic                     hist_shift;

   fir_inv_hist #(.W(DW_OUT)) u_hist (
      .clk      (clk),
      .rst      (rst),
      .shift_en (hist_shift),
      .din      (x_out_d),
      .h1       (h1),
      .h2       (h2),
      .h3       (h3),
      .h4       (h4)
   );

   // The tap index doubles as the shift amount: h1<<1 .. h4<<4.
   always_comb begin
      case (tap_q)
         3'd1:    h_sel = h1;
         3'd2:    h_sel = h2;
         3'd3:    h_sel = h3;
         3'd4:    h_sel = h4;
         default: h_sel = '0;
      endcase
      sub_term = {{(ACC_W-DW_OUT){1'b0}}, h_sel} << tap_q;
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      tap_d      = tap_q;
      x_out_d    = x_out_q;
      x_valid_d  = x_valid_q;
      y_ready_d  = y_ready_q;
      hist_shift = 1'b0;
`ifdef FIR_INV_SAT_FLAG_EN
      sat_d      = sat_q;
`endif
      case (state_q)
         IDLE: begin
            y_ready_d = 1'b1;
            if (bus.y_valid && y_ready_q) begin
               acc_d     = $signed({{(ACC_W-DW_IN-5){1'b0}}, bus.y_in, 5'b0});
               tap_d     = 3'(TAP_FIRST);
               y_ready_d = 1'b0;
               state_d   = CALC;
            end
         end
         CALC: begin
            if (tap_q <= 3'(TAP_LAST)) begin
               acc_d = acc_q - $signed(sub_term);
               tap_d = tap_q + 3'd1;
            end else begin
               x_out_d    = clamp_acc(acc_q);
               x_valid_d  = 1'b1;
               hist_shift = 1'b1;
`ifdef FIR_INV_SAT_FLAG_EN
               sat_d      = is_sat(acc_q);
`endif
               state_d    = OUT;
            end
         end
         OUT: begin
            if (x_valid_q && bus.x_ready) begin
               x_valid_d = 1'b0;
               y_ready_d = 1'b1;
`ifdef FIR_INV_SAT_FLAG_EN
               sat_d     = 1'b0;
`endif
               state_d   = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            y_ready_d = 1'b0;
            x_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         tap_q     <= '0;
         x_out_q   <= '0;
         x_valid_q <= 1'b0;
         y_ready_q <= 1'b0;
`ifdef FIR_INV_SAT_FLAG_EN
         sat_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         tap_q     <= tap_d;
         x_out_q   <= x_out_d;
         x_valid_q <= x_valid_d;
         y_ready_q <= y_ready_d;
`ifdef FIR_INV_SAT_FLAG_EN
         sat_q     <= sat_d;
`endif
      end
   end

   assign bus.y_ready = y_ready_q;
   assign bus.x_out   = x_out_q;
   assign bus.x_valid = x_valid_q;
`ifdef FIR_INV_SAT_FLAG_EN
   assign bus.sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_fir_inverse_seq.sv
// Directed bench for fir_inverse_seq: hand-computed samples, latency, backpressure, reset abort, throughput.
// Build with FIR_INV_SAT_FLAG_EN defined to also check sat_flag.
module tb_fir_inverse_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fir_inverse_seq_if bus();

   fir_inverse_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_sat(input string tag, input int exp);
`ifdef FIR_INV_SAT_FLAG_EN
      chk(tag, int'(bus.sat_flag), exp);
`endif
   endtask

   task automatic do_reset(input string tag);
      rst         = 1'b1;
      bus.y_valid = 1'b0;
      bus.x_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk({tag, "_rst_xvalid"}, int'(bus.x_valid), 0);
      chk({tag, "_rst_xout"},   int'(bus.x_out),   0);
      chk({tag, "_rst_yready"}, int'(bus.y_ready), 0);
      chk_sat({tag, "_rst_sat"}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_idle_yready"}, int'(bus.y_ready), 1);
   endtask

   // One sample through: accept, latency, value, optional hold under backpressure, drain.
   task automatic do_sample(input logic [9:0] yv, input int ex, input int es,
                            input int hold, input string tag);
      int cyc;
      int lat;
      cyc = 0;
      while (!bus.y_ready && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_yready"}, int'(bus.y_ready), 1);
      bus.y_in    = yv;
      bus.y_valid = 1'b1;
      @(posedge clk); #1;
      bus.y_valid = 1'b0;
      lat = 0;
      while (!bus.x_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"},  lat, 5);
      chk({tag, "_xout"}, int'(bus.x_out), ex);
      chk_sat({tag, "_sat"}, es);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_xvalid"}, int'(bus.x_valid), 1);
         chk({tag, "_hold_xout"},   int'(bus.x_out),   ex);
         chk({tag, "_hold_yready"}, int'(bus.y_ready), 0);
      end
      bus.x_ready = 1'b1;
      @(posedge clk); #1;
      bus.x_ready = 1'b0;
      chk({tag, "_drain_xvalid"}, int'(bus.x_valid), 0);
      chk({tag, "_drain_yready"}, int'(bus.y_ready), 1);
      chk_sat({tag, "_drain_sat"}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] imp_y [6];
      int         imp_x [6];
      logic [9:0] b2b_y [3];
      int         b2b_x [3];
      int         seen;
      int         n_acc;
      int         n_out;
      int         last_acc;
      logic       acc_now;
      logic       out_now;

      imp_y = '{10'd2, 10'd4, 10'd8, 10'd16, 10'd32, 10'd0};
      imp_x = '{64, 0, 0, 0, 0, 0};
      b2b_y = '{10'd2, 10'd4, 10'd8};
      b2b_x = '{64, 0, 0};

      bus.y_in    = '0;
      bus.y_valid = 1'b0;
      bus.x_ready = 1'b0;

      // zero input from reset
      do_reset("r0");
      do_sample(10'd0, 0, 0, 0, "zero");

      // forward-filter impulse of x=64 recovers as 64 then zeros
      for (int i = 0; i < 6; i++) begin
         do_sample(imp_y[i], imp_x[i], 0, 0, $sformatf("imp%0d", i));
      end

      // 32736 clamps high; then 0 - 2*255 = -510 clamps low
      do_reset("r1");
      do_sample(10'd1023, 255, 1, 0, "sat_hi");
      do_sample(10'd0,    0,   1, 0, "sat_lo");

      // three cycles of backpressure in OUT
      do_reset("r2");
      do_sample(10'd2, 64, 0, 3, "bp");

      // reset during CALC (tap=2) aborts the sample and clears history (h1 was 64)
      bus.y_in    = 10'd1023;
      bus.y_valid = 1'b1;
      @(posedge clk); #1;
      bus.y_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_rst_yready", int'(bus.y_ready), 0);
      chk("abort_rst_xvalid", int'(bus.x_valid), 0);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.x_valid) seen++;
      end
      chk("abort_no_output", seen, 0);
      do_sample(10'd2, 64, 0, 0, "post_abort");

      // y_valid held high, x_ready held high: one accept per 7 cycles
      do_reset("r3");
      n_acc       = 0;
      n_out       = 0;
      last_acc    = -1;
      bus.y_in    = b2b_y[0];
      bus.y_valid = 1'b1;
      bus.x_ready = 1'b1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk);
         acc_now = bus.y_valid && bus.y_ready;
         out_now = bus.x_valid && bus.x_ready;
         if (out_now) begin
            if (n_out < 3) chk($sformatf("b2b_xout%0d", n_out), int'(bus.x_out), b2b_x[n_out]);
            n_out++;
         end
         if (acc_now) begin
            if (last_acc >= 0) chk($sformatf("b2b_ii%0d", n_acc), cyc - last_acc, 7);
            last_acc = cyc;
            n_acc++;
         end
         @(posedge clk); #1;
         if (acc_now) begin
            if (n_acc < 3) bus.y_in = b2b_y[n_acc];
            else           bus.y_valid = 1'b0;
         end
      end
      chk("b2b_accepts", n_acc, 3);
      chk("b2b_outputs", n_out, 3);
      bus.x_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fir_inverse_seq.md
Name: fir_inverse_seq

Overview:
- Inverse (recovery) filter for the 5-tap shift-coefficient FIR. It reconstructs an 8-bit sample estimate from each 10-bit filtered sample.
- Forward relation: y[n] = (x[n]>>5)+(x[n-1]>>4)+(x[n-2]>>3)+(x[n-3]>>2)+(x[n-4]>>1).
- Inverse computed: x̂[n] = clamp(32·y[n] − 2·x̂[n-1] − 4·x̂[n-2] − 8·x̂[n-3] − 16·x̂[n-4], 0, 255).
- Sits at the receive end of the filter path. Sequential: one shift-subtract per cycle, valid/ready on both sides.

Parameters:
- DW_IN, 10, width of filtered input sample.
- DW_OUT, 8, width of recovered sample (unsigned).
- ACC_W, 17, signed accumulator width. Covers range −7650..32736.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- y_in  in  DW_IN  filtered sample, unsigned
- y_valid  in  1  y_in valid
- y_ready  out  1  block can accept y_in
- x_out  out  DW_OUT  recovered sample
- x_valid  out  1  x_out valid
- x_ready  in  1  downstream accepts x_out
- sat_flag  out  1  only when SAT_FLAG_EN is defined (see Optional Feature)

Behaviour:
- Reset: rst sampled on posedge clk only.
  - state=IDLE; y_ready=0 during the reset cycle, then 1 in IDLE.
  - x_valid=0, x_out=0, acc=0, tap=0; history h1..h4=0; sat_flag=0.
  - Reset mid-operation aborts the sample in flight; no output is produced and history is cleared.
- States: IDLE, CALC, OUT.
- IDLE: y_ready=1. On y_valid&&y_ready at edge T: acc<={y_in,5'b0} (zero-extended), tap<=1, go CALC.
- CALC: y_ready=0. Each edge: acc<=acc−(h_tap<<tap), i.e. h1·2, h2·4, h3·8, h4·16; tap++. After the tap-4 edge (T+4), go OUT.
- Transition into OUT (edge T+5):
  - x_out<=clamp(acc): acc<0 gives 0; acc>255 gives 255; otherwise acc[7:0].
  - x_valid<=1.
  - History shifts: h4<=h3, h3<=h2, h2<=h1, h1<=clamped value.
  - Latency from accept to x_valid: 5 cycles.
- OUT: x_out and x_valid held stable while x_ready=0. y_ready=0.
  - On x_valid&&x_ready at an edge: x_valid<=0, go IDLE.
  - Minimum initiation interval: 7 cycles.
- Arithmetic: signed two's-complement acc, no wrap possible at ACC_W=17. History stores clamped values only.
- Simultaneous events:
  - y_valid asserted outside IDLE is ignored; the source holds it.
  - rst has priority over every handshake.
- x_ready is permitted high before x_valid; it has no effect until OUT.

Optional Feature:
- Macro FIR_INV_SAT_FLAG_EN.
- Defined: port sat_flag exists. It is registered alongside x_out and high while x_valid=1 if clamping occurred (acc<0 or acc>255). It clears with x_valid.
- Undefined: port and logic absent. Clamping behaviour is identical.

Decomposition:
- Shared package/include fir_inv_pkg:
  - state encoding IDLE/CALC/OUT
  - DW_IN, DW_OUT, ACC_W defaults
  - tap shift constants 1..4
  - clamp bounds 0/255
- Sub-module fir_inv_hist: 4-deep DW_OUT history register. Synchronous reset, shift-enable input, four parallel outputs. Instantiated once.

Test Plan:
- Reset, then y_in=0 → x_out=0 at T+5; sat_flag=0.
- Impulse response of forward filter (x=64 then zeros), y_in sequence 2,4,8,16,32,0 → x_out sequence 64,0,0,0,0,0. No saturation.
- From reset, y_in=1023 → acc=32736 → x_out=255, sat_flag=1. Then y_in=0 → acc=−510 → x_out=0, sat_flag=1.
- Backpressure: x_ready held 0 for 3 cycles in OUT → x_out/x_valid stable, y_ready=0 throughout. One cycle after accept, y_ready=1.
- rst asserted during CALC (tap=2) → no x_valid; history zero. Next y_in=2 → x_out=64.
- Back-to-back y_valid held high with x_ready=1 → one accept per 7 cycles; each sample accepted exactly once.
